keypad_scan_ctrl: RTL and testbench

Single-clock controller that sequences a 4x4 matrix keypad: drives the column scan, synchronizes and debounces the row returns, encodes the accepted key to a hex nibble, and shifts it into an N-digit value register for the multiplexed seven-segment controller. It replaces free-running keypad logic with a tick-enabled FSM, so all state lives in the CLK domain. The scan rate comes from a clock-ladder-derived strobe.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_scan_ctrl_row_sync.sv | 23 ++
 rtl/keypad_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the keypad scan controller.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    // Hex code of each key, indexed [row][col].
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // One-cold column drive: only the selected column is pulled low.
    function automatic logic [3:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_row_sync.sv
`timescale 1ns/1ps
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
module row_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows_raw,
    output logic [3:0] rows_synced
);

    logic [3:0] meta_q;

    // Resets to all-ones so an idle keypad (all rows pulled up) is the reset view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q      <= 4'hF;
            rows_synced <= 4'hF;
        end else begin
            meta_q      <= rows_raw;
            rows_synced <= meta_q;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
`timescale 1ns/1ps
// Tick-driven 4x4 keypad scanner with debounce, key encode and a digit shift register.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 3,
    parameter int N              = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick,
    input  logic           clear,
    input  logic [3:0]     rows,
    output logic [3:0]     cols,
    output logic           pressed,
    output logic           key_valid,
    output logic [3:0]     key,
    output logic [4*N-1:0] value
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DEBOUNCE_TICKS);
    localparam int                VAL_W    = 4 * N;

    scan_state_t      state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       rs;
    logic             hit;
    logic [1:0]       hit_row;
    logic             accept;
    logic [3:0]       key_code;

    row_sync u_row_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .rows_raw    (rows),
        .rows_synced (rs)
    );

    // Find the lowest-index row pulled low; that row wins when several are low.
    always_comb begin
        hit     = 1'b0;
        hit_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs[i]) begin
                hit     = 1'b1;
                hit_row = 2'(i);
            end
        end
    end

    // Next-state logic; the FSM only moves on tick cycles, and col stays frozen while a key is tracked.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        cnt_inc  = cnt_q + CNT_W'(1);
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (hit) begin
                        row_d = hit_row;
                        cnt_d = CNT_W'(1);
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d = HELD;
                            accept  = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (hit && (hit_row == row_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_d = HELD;
                            accept  = 1'b1;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
                HELD: begin
                    if (rs[row_q]) begin
                        cnt_d = CNT_W'(1);
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d = SCAN;
                            col_d   = col_q + 2'd1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (rs[row_q]) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_d = SCAN;
                            col_d   = col_q + 2'd1;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

    // Code of the key under the row being latched and the frozen column.
    always_comb begin
        key_code = KEY_MAP[row_d][col_q];
        pressed  = (state_q == HELD) || (state_q == RELEASE);
    end

    // FSM state, scan position and the registered column drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            cnt_q   <= '0;
            cols    <= 4'b1110;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            cols    <= col_drive(col_d);
        end
    end

    // Accepted-key outputs; a clear in the accept cycle keeps only the new digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key       <= 4'h0;
            value     <= '0;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key <= key_code;
            end
            if (clear) begin
                value <= accept ? VAL_W'(key_code) : '0;
            end else if (accept) begin
                value <= (value << 4) | VAL_W'(key_code);
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for keypad_scan_ctrl with a keypad matrix model.
module tb_keypad_scan_ctrl;

    typedef struct packed {
        logic [3:0]  key;
        logic [15:0] value;
    } exp_t;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        tick         = 1'b0;
    logic        clear_tick   = 1'b0;
    logic        clear_direct = 1'b0;
    logic        clear;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        pressed;
    logic        key_valid;
    logic [3:0]  key;
    logic [15:0] value;
    logic [15:0] keys_down    = 16'h0000;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   phase    = 0;
    int   clr_cnt  = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    keypad_scan_ctrl #(
        .DEBOUNCE_TICKS (3),
        .N              (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .clear     (clear),
        .rows      (rows),
        .cols      (cols),
        .pressed   (pressed),
        .key_valid (key_valid),
        .key       (key),
        .value     (value)
    );

    always #5 clk = ~clk;

    assign clear = clear_tick | clear_direct;

    // Keypad matrix: a held key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys_down[r*4+c] && !cols[c]) begin
                    rows[r] = 1'b0;
                end
            end
        end
    end

    // Scan strobe every 4 clocks; can also raise clear together with a chosen upcoming tick.
    initial begin
        forever begin
            @(negedge clk);
            phase = (phase + 1) % 4;
            tick  = (phase == 0);
            if (tick && clr_cnt != 0) begin
                clear_tick = (clr_cnt == 1);
                clr_cnt--;
            end else begin
                clear_tick = 1'b0;
            end
        end
    end

    function automatic logic [15:0] keyBit(input int r, input int c);
        return 16'(1) << (r * 4 + c);
    endfunction

    function automatic logic [3:0] colOneCold(input int c);
        return ~(4'b0001 << c);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitTicks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (tick !== 1'b1) @(posedge clk);
        end
    endtask

    // Wait until the scan freshly enters the column whose drive is target.
    task automatic waitColsEntry(input logic [3:0] target, input string name);
        int budget = 200;
        while (cols === target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        while (cols !== target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: cols %b, expected %b", name, cols, target);
        end
    endtask

    // One full press/hold/release of the keys in mask, which all sit in column col.
    task automatic applyStimulus(input logic [15:0] mask, input int col, input logic [3:0] exp_key,
                                 input logic [15:0] exp_value, input bit glitch, input bit clr_at_accept,
                                 input string name);
        exp_t e;
        e.key   = exp_key;
        e.value = exp_value;
        exp_q.push_back(e);
        waitColsEntry(4'b1110, {name, "_col0"});
        keys_down = mask;
        if (clr_at_accept) begin
            waitColsEntry(colOneCold(col), {name, "_colkey"});
            clr_cnt = 3;
            waitTicks(6);
        end else begin
            waitTicks(col + 6);
        end
        @(negedge clk);
        checkOutput({name, "_pressed_held"}, 32'(pressed), 32'd1);
        keys_down = 16'h0000;
        if (glitch) begin
            waitTicks(1);
            @(negedge clk);
            checkOutput({name, "_pressed_rel1"}, 32'(pressed), 32'd1);
            keys_down = mask;
            waitTicks(1);
            @(negedge clk);
            checkOutput({name, "_pressed_glitch"}, 32'(pressed), 32'd1);
            keys_down = 16'h0000;
        end
        waitTicks(1);
        @(negedge clk);
        checkOutput({name, "_pressed_rt1"}, 32'(pressed), 32'd1);
        waitTicks(1);
        @(negedge clk);
        checkOutput({name, "_pressed_rt2"}, 32'(pressed), 32'd1);
        waitTicks(1);
        @(negedge clk);
        checkOutput({name, "_pressed_rt3"}, 32'(pressed), 32'd0);
        checkOutput({name, "_cols_next"}, 32'(cols), 32'(colOneCold((col + 1) % 4)));
        checkOutput({name, "_key"}, 32'(key), 32'(exp_key));
    endtask

    // Monitor: every key_valid strobe must match the oldest expected accept.
    initial begin
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_key_valid: got key %h value %h, expected no accept", key, value);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("sb_key", 32'(key), 32'(mon_e.key));
                    checkOutput("sb_value", 32'(value), 32'(mon_e.value));
                    checkOutput("sb_pressed", 32'(pressed), 32'd1);
                end
            end
        end
    end

    // Global time limit.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus.
    initial begin
        logic [3:0] scan_seq [4];
        scan_seq[0] = 4'b1101;
        scan_seq[1] = 4'b1011;
        scan_seq[2] = 4'b0111;
        scan_seq[3] = 4'b1110;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_cols", 32'(cols), 32'h0000000E);
        checkOutput("rst_pressed", 32'(pressed), 32'd0);
        checkOutput("rst_key_valid", 32'(key_valid), 32'd0);
        checkOutput("rst_key", 32'(key), 32'd0);
        checkOutput("rst_value", 32'(value), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            waitTicks(1);
            @(negedge clk);
            checkOutput("idle_cols", 32'(cols), 32'(scan_seq[i]));
            checkOutput("idle_pressed", 32'(pressed), 32'd0);
        end
        checkOutput("idle_value", 32'(value), 32'd0);

        applyStimulus(keyBit(1, 2), 2, 4'h6, 16'h0006, 1'b0, 1'b0, "key6");

        applyStimulus(keyBit(0, 0), 0, 4'h1, 16'h0061, 1'b0, 1'b0, "seq1");
        applyStimulus(keyBit(0, 3), 3, 4'hA, 16'h061A, 1'b0, 1'b0, "seqA");
        applyStimulus(keyBit(3, 1), 1, 4'h0, 16'h61A0, 1'b0, 1'b0, "seq0");
        applyStimulus(keyBit(3, 3), 3, 4'hD, 16'h1A0D, 1'b0, 1'b0, "seqD");
        applyStimulus(keyBit(1, 1), 1, 4'h5, 16'hA0D5, 1'b1, 1'b0, "seq5_glitch");

        waitColsEntry(4'b1110, "bounce_col0");
        keys_down = keyBit(0, 0);
        waitTicks(2);
        @(negedge clk);
        keys_down = 16'h0000;
        waitTicks(1);
        @(negedge clk);
        checkOutput("bounce_cols", 32'(cols), 32'h0000000D);
        checkOutput("bounce_pressed", 32'(pressed), 32'd0);
        waitTicks(4);
        @(negedge clk);
        checkOutput("bounce_value", 32'(value), 32'h0000A0D5);

        applyStimulus(keyBit(0, 0), 0, 4'h1, 16'h0D51, 1'b0, 1'b0, "fill1");
        applyStimulus(keyBit(0, 1), 1, 4'h2, 16'hD512, 1'b0, 1'b0, "fill2");
        applyStimulus(keyBit(0, 2), 2, 4'h3, 16'h5123, 1'b0, 1'b0, "fill3");
        applyStimulus(keyBit(1, 0), 0, 4'h4, 16'h1234, 1'b0, 1'b0, "fill4");
        applyStimulus(keyBit(2, 2), 2, 4'h9, 16'h0009, 1'b0, 1'b1, "clr_accept9");

        @(negedge clk);
        clear_direct = 1'b1;
        @(negedge clk);
        clear_direct = 1'b0;
        checkOutput("clear_value", 32'(value), 32'd0);
        checkOutput("clear_key", 32'(key), 32'h9);

        applyStimulus(keyBit(2, 1) | keyBit(3, 1), 1, 4'h8, 16'h0008, 1'b0, 1'b0, "multirow8");

        waitColsEntry(4'b1110, "rst_col0");
        keys_down = keyBit(0, 0);
        waitTicks(1);
        @(negedge clk);
        checkOutput("debounce_pressed", 32'(pressed), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_cols", 32'(cols), 32'h0000000E);
        checkOutput("midrst_pressed", 32'(pressed), 32'd0);
        checkOutput("midrst_key_valid", 32'(key_valid), 32'd0);
        checkOutput("midrst_key", 32'(key), 32'd0);
        checkOutput("midrst_value", 32'(value), 32'd0);
        @(negedge clk);
        keys_down = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        waitTicks(1);
        @(negedge clk);
        checkOutput("postrst_cols", 32'(cols), 32'h0000000D);
        waitTicks(4);
        @(negedge clk);
        checkOutput("postrst_value", 32'(value), 32'd0);

        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
